// File: rtl/audio_pkg.sv
// audio_pkg: constants and types shared by the PDM capture block and the
// I2S amplifier transmitter.
//   SAMPLE_W   - PCM sample width
//   SLOT_W     - I2S slot width (bits per channel)
//   FRAME_BITS - bits per I2S frame (two slots)
//   sample_t   - signed PCM sample type
//   slot_bit() - serial data bit for a given position within a slot
package audio_pkg;

    localparam int SAMPLE_W   = 18;
    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 64;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Philips framing: MSB goes out one bit after the WS edge, the slot
    // tail past the LSB is zero-padded.
    function automatic logic slot_bit(input sample_t s, input logic [4:0] p);
        if (p >= 5'd1 && p <= 5'(SAMPLE_W)) begin
            return s[5'(SAMPLE_W) - p];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO, single-cycle push and pop.
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low reset (empties the FIFO)
//   flush_i - synchronous flush (empties the FIFO)
//   push_i  - write data_i (accepted if not full, or if a pop frees a slot)
//   data_i  - write data
//   pop_i   - remove the head entry (ignored when empty)
//   data_o  - head entry, valid while not empty
//   full_o  - FIFO holds DEPTH entries
//   empty_o - FIFO holds no entries
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/i2s_amp_tx.sv
// i2s_amp_tx: buffers mono PCM samples and serialises them as Philips I2S
// frames (same sample in left and right slots) for a MAX98357A amplifier.
//   clk_i      - system clock, rising edge
//   reset_n_i  - synchronous active-low reset
//   enable_i   - 1 = run, 0 = idle (flush FIFO, clear flags, outputs low)
//   s_valid_i  - one-cycle strobe, s_data_i holds a new sample
//   s_data_i   - signed PCM sample
//   bclk_o     - I2S bit clock, clk_i / (2*CLK_DIV)
//   ws_o       - I2S word select, 0 = left, 1 = right
//   sd_o       - I2S serial data, MSB first
//   overflow_o - sticky, a sample was dropped on a full FIFO
//   underrun_o - sticky, a frame started with the FIFO empty
module i2s_amp_tx
    import audio_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    reset_n_i,
    input  logic    enable_i,
    input  logic    s_valid_i,
    input  sample_t s_data_i,
    output logic    bclk_o,
    output logic    ws_o,
    output logic    sd_o,
    output logic    overflow_o,
    output logic    underrun_o
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d, bit_nxt;
    logic             bclk_q, bclk_d;
    logic             ws_q, ws_d;
    logic             sd_q, sd_d;
    logic             ovf_q, ovf_d;
    logic             und_q, und_d;
    sample_t          frame_q, frame_d;

    logic                div_tc, fall, frame_start, push;
    logic [SAMPLE_W-1:0] fifo_rdata;
    logic                fifo_full, fifo_empty;

    assign div_tc      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign fall        = div_tc && bclk_q;
    assign bit_nxt     = bit_q + BIT_W'(1);
    assign frame_start = fall && (bit_nxt == '0);
    assign push        = s_valid_i && enable_i;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (reset_n_i),
        .flush_i (!enable_i),
        .push_i  (push),
        .data_i  (s_data_i),
        .pop_i   (frame_start),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        div_cnt_d = div_tc ? '0 : div_cnt_q + DIV_W'(1);
        bclk_d    = div_tc ? !bclk_q : bclk_q;
        bit_d     = bit_q;
        ws_d      = ws_q;
        sd_d      = sd_q;
        frame_d   = frame_q;
        ovf_d     = ovf_q;
        und_d     = und_q;

        if (frame_start) begin
            if (fifo_empty) begin
                frame_d = '0;
                und_d   = 1'b1;
            end else begin
                frame_d = sample_t'(fifo_rdata);
            end
        end

        if (fall) begin
            bit_d = bit_nxt;
            // WS leads the slot by one bit: high for b = 31..62.
            ws_d  = (bit_nxt >= BIT_W'(SLOT_W - 1)) && (bit_nxt != BIT_W'(FRAME_BITS - 1));
            sd_d  = slot_bit(frame_d, bit_nxt[4:0]);
        end

        // A full FIFO only drops the sample when no pop frees a slot.
        if (push && fifo_full && !frame_start) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || !enable_i) begin
            div_cnt_q <= '0;
            bit_q     <= BIT_W'(FRAME_BITS - 1);
            bclk_q    <= 1'b0;
            ws_q      <= 1'b0;
            sd_q      <= 1'b0;
            frame_q   <= '0;
            ovf_q     <= 1'b0;
            und_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_q     <= bit_d;
            bclk_q    <= bclk_d;
            ws_q      <= ws_d;
            sd_q      <= sd_d;
            frame_q   <= frame_d;
            ovf_q     <= ovf_d;
            und_q     <= und_d;
        end
    end

    assign bclk_o     = bclk_q;
    assign ws_o       = ws_q;
    assign sd_o       = sd_q;
    assign overflow_o = ovf_q;
    assign underrun_o = und_q;

endmodule

// File: tb/tb_i2s_amp_tx.sv
// tb_i2s_amp_tx: self-checking bench for i2s_amp_tx with CLK_DIV=2.
// A cycle-count based reference model predicts every output each cycle;
// directed sequences additionally check decoded frames and flags.
module tb_i2s_amp_tx;

    localparam int D     = 2;
    localparam int PER   = 2 * D;
    localparam int FR    = 64 * PER;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, en, vld;
    logic [17:0] data;
    logic        bclk, ws, sd, ovf, und;

    i2s_amp_tx #(
        .CLK_DIV    (D),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .enable_i   (en),
        .s_valid_i  (vld),
        .s_data_i   (data),
        .bclk_o     (bclk),
        .ws_o       (ws),
        .sd_o       (sd),
        .overflow_o (ovf),
        .underrun_o (und)
    );

    always #5 clk = !clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state: enabled-cycle count, sample queue, flags
    int          m_n = 0;
    logic [17:0] m_q[$];
    logic        m_ovf = 1'b0, m_und = 1'b0;
    logic [17:0] m_frame = '0;

    logic fall_sd[$];
    logic fall_ws[$];
    int   rise_cyc[$];
    logic prev_bclk = 1'b0;
    int   cyc_cnt = 0;

    typedef struct {
        logic        rst_n, en, vld;
        logic [17:0] data;
        logic [4:0]  exp;   // {bclk, ws, sd, overflow, underrun}
    } vec_t;
    vec_t tbl[13];

    logic [17:0] s[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int f, b;
        if (!rst_n || !en) begin
            m_n = 0;
            m_q.delete();
            m_ovf = 1'b0;
            m_und = 1'b0;
            m_frame = '0;
        end else begin
            m_n++;
            if (m_n % PER == 0) begin
                f = m_n / PER;
                b = (f - 1) % 64;
                if (b == 0) begin
                    if (m_q.size() > 0) m_frame = m_q.pop_front();
                    else begin
                        m_frame = '0;
                        m_und = 1'b1;
                    end
                end
            end
            if (vld) begin
                if (m_q.size() < DEPTH) m_q.push_back(data);
                else m_ovf = 1'b1;
            end
        end
    endtask

    function automatic logic [4:0] model_out();
        int f, b, p;
        logic e_bclk, e_ws, e_sd;
        f = m_n / PER;
        e_bclk = ((m_n / D) % 2) == 1;
        e_ws = 1'b0;
        e_sd = 1'b0;
        if (f > 0) begin
            b = (f - 1) % 64;
            p = b % 32;
            e_ws = ((b + 1) % 64) >= 32;
            if (p >= 1 && p <= 18) e_sd = m_frame[18 - p];
        end
        return {e_bclk, e_ws, e_sd, m_ovf, m_und};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model", {59'd0, bclk, ws, sd, ovf, und}, {59'd0, model_out()});
        if (prev_bclk && !bclk) begin
            fall_sd.push_back(sd);
            fall_ws.push_back(ws);
        end
        if (!prev_bclk && bclk) rise_cyc.push_back(cyc_cnt);
        prev_bclk = bclk;
        cyc_cnt++;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (m_n < target && guard < 20000) begin
            cyc();
            guard++;
        end
        if (m_n < target) chk("run_to_timeout", 64'(m_n), 64'(target));
    endtask

    task automatic clr();
        fall_sd.delete();
        fall_ws.delete();
        rise_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; vld = 1'b0; data = '0;
        repeat (3) cyc();
        rst_n = 1'b1; en = 1'b0;
        cyc();
        clr();
    endtask

    function automatic logic [63:0] fword(input logic q[$], input int fi);
        logic [63:0] w;
        w = 'x;
        if (q.size() >= (fi + 1) * 64)
            for (int b = 0; b < 64; b++) w[b] = q[fi * 64 + b];
        return w;
    endfunction

    // frame as seen on SD, bit b = value sent at frame bit b
    function automatic logic [63:0] exp_word(input logic [17:0] smp);
        logic [63:0] w;
        int p;
        w = '0;
        for (int b = 0; b < 64; b++) begin
            p = b % 32;
            if (p >= 1 && p <= 18) w[b] = smp[18 - p];
        end
        return w;
    endfunction

    initial begin
        int burst, off;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 18'h0,     5'b00000};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 18'h0,     5'b00000};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 18'h0,     5'b00000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 18'h0,     5'b00000};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 18'h1234,  5'b00000};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 18'h0,     5'b00000};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 18'h0,     5'b10000};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 18'h0,     5'b10000};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 18'h0,     5'b00001};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 18'h0,     5'b00001};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 18'h0,     5'b10001};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 18'h3FFFF, 5'b00000};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 18'h0,     5'b00000};

        rst_n = 1'b0; en = 1'b0; vld = 1'b0; data = '0;
        for (int i = 0; i < 13; i++) begin
            rst_n = tbl[i].rst_n;
            en    = tbl[i].en;
            vld   = tbl[i].vld;
            data  = tbl[i].data;
            cyc();
            chk($sformatf("tbl%0d", i), {59'd0, bclk, ws, sd, ovf, und}, {59'd0, tbl[i].exp});
        end
        vld = 1'b0;
        repeat (40) cyc();
        chk("idle_bclk", {63'd0, bclk}, 64'd0);

        // single frame: 18'h2AAAB in both slots, then an underrun frame
        do_reset();
        en = 1'b1; vld = 1'b1; data = 18'h2AAAB;
        cyc();
        vld = 1'b0;
        run_to(2 * FR);
        chk("frame_2aaab", fword(fall_sd, 0), exp_word(18'h2AAAB));
        chk("frame_zero", fword(fall_sd, 1), 64'd0);
        chk("ws_pattern", fword(fall_ws, 0), 64'h7FFFFFFF_80000000);
        if (rise_cyc.size() >= 2) chk("bclk_period", 64'(rise_cyc[1] - rise_cyc[0]), 64'd4);
        else chk("bclk_rises", 64'(rise_cyc.size()), 64'd2);
        chk("flags_a", {62'd0, ovf, und}, 64'b01);

        // underrun, then a full-scale sample
        do_reset();
        en = 1'b1;
        repeat (3) cyc();
        chk("und_before", {63'd0, und}, 64'd0);
        cyc();
        chk("und_after", {63'd0, und}, 64'd1);
        run_to(100);
        vld = 1'b1; data = 18'h3FFFF;
        cyc();
        vld = 1'b0;
        run_to(3 * FR);
        chk("frame_und0", fword(fall_sd, 0), 64'd0);
        chk("frame_ones", fword(fall_sd, 1), exp_word(18'h3FFFF));
        chk("und_sticky", {63'd0, und}, 64'd1);

        // overflow: five consecutive pushes into a four-entry FIFO
        do_reset();
        for (int i = 0; i < 5; i++) s[i] = 18'($urandom);
        en = 1'b1;
        run_to(10);
        for (int i = 0; i < 5; i++) begin
            vld = 1'b1; data = s[i];
            cyc();
            chk($sformatf("ovf_push%0d", i), {63'd0, ovf}, {63'd0, (i == 4)});
        end
        vld = 1'b0;
        run_to(6 * FR);
        for (int i = 0; i < 4; i++)
            chk($sformatf("ovf_frame%0d", i + 1), fword(fall_sd, i + 1), exp_word(s[i]));
        chk("ovf_dropped", fword(fall_sd, 5), 64'd0);

        // push on the exact pop cycle with the FIFO full
        do_reset();
        for (int i = 0; i < 5; i++) s[i] = 18'($urandom);
        en = 1'b1;
        run_to(9);
        for (int i = 0; i < 4; i++) begin
            vld = 1'b1; data = s[i];
            cyc();
        end
        vld = 1'b0;
        run_to(FR + PER - 1);
        vld = 1'b1; data = s[4];
        cyc();
        vld = 1'b0;
        chk("pp_no_ovf", {63'd0, ovf}, 64'd0);
        run_to(7 * FR);
        for (int i = 0; i < 5; i++)
            chk($sformatf("pp_frame%0d", i + 1), fword(fall_sd, i + 1), exp_word(s[i]));
        chk("pp_tail", fword(fall_sd, 6), 64'd0);
        chk("pp_ovf_end", {63'd0, ovf}, 64'd0);

        // mid-frame disable at b=20, re-enable after 10 cycles
        do_reset();
        for (int i = 0; i < 3; i++) s[i] = 18'($urandom);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vld = 1'b1; data = s[i];
            cyc();
        end
        vld = 1'b0;
        run_to(21 * PER);
        en = 1'b0;
        cyc();
        chk("dis_outputs", {59'd0, bclk, ws, sd, ovf, und}, 64'd0);
        repeat (9) cyc();
        en = 1'b1;
        clr();
        repeat (3) cyc();
        chk("reen_und0", {63'd0, und}, 64'd0);
        cyc();
        chk("reen_und1", {63'd0, und}, 64'd1);
        run_to(2 * FR);
        chk("reen_frame0", fword(fall_sd, 0), 64'd0);
        chk("reen_frame1", fword(fall_sd, 1), 64'd0);

        // randomized traffic, bursts, enable drops and resets
        do_reset();
        en = 1'b1;
        burst = 0;
        off = 0;
        for (int i = 0; i < 6000; i++) begin
            if (burst > 0) begin
                vld = 1'b1;
                burst--;
            end else begin
                vld = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 299) == 0) burst = $urandom_range(2, 6);
            end
            data = 18'($urandom);
            if (off > 0) begin
                en = 1'b0;
                off--;
            end else begin
                en = 1'b1;
                if ($urandom_range(0, 1999) == 0) off = $urandom_range(1, 20);
            end
            rst_n = ($urandom_range(0, 4999) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
